imem_boot_loader: RTL and testbench
===================================

Name: imem_boot_loader

Overview:
- Loads a program into the 256 x 16-bit instruction memory from a byte-wide streaming host interface, then releases the CPU to run.
- Sits between the host or debug link and the instruction memory write port.
- Holds the CPU out of execution (cpu_run_o low) while loading. Re-entering load from run is allowed.
- Words use the CPU's 16-bit instruction format and are written unmodified (no decode).

Parameters:
- DEPTH, 256, number of instruction words in memory. Must be a power of 2, at most 65536.
- AW, 8, write address width; equals log2(DEPTH).
- MAX_LEN, DEPTH, largest accepted word count.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- load_req_i  input  1  single-cycle pulse: start a new load session.
- s_valid_i  input  1  host byte valid.
- s_data_i  input  8  host byte.
- s_ready_o  output  1  loader can accept a byte this cycle.
- wr_en_o  output  1  instruction memory write strobe, one cycle.
- wr_addr_o  output  AW  write address.
- wr_data_o  output  16  write data (instruction word).
- cpu_run_o  output  1  high means the CPU may fetch and execute; low holds the CPU PC at 0.
- busy_o  output  1  load session in progress.
- err_o  output  1  sticky error flag; cleared by load_req_i.
- words_loaded_o  output  AW+1  count of words written in the current or last session.

Behaviour:
- Reset values (async on rst_n low): state IDLE, s_ready_o=0, wr_en_o=0, wr_addr_o=0, wr_data_o=0, cpu_run_o=0, busy_o=0, err_o=0, words_loaded_o=0.
- Stream frame, in byte order:
  - LEN_HI, LEN_LO: the 16-bit word count N.
  - N words, each sent as HI byte then LO byte.
  - Checksum trailer only when the optional feature is enabled.
- A byte transfers when s_valid_i and s_ready_o are both high on a rising edge.
- s_ready_o is a registered output and does not depend on s_valid_i.
- States and transitions:
  - IDLE: cpu_run_o=0. On load_req_i go to LEN_HI.
  - LEN_HI: s_ready_o=1. Capture the high byte of N, then go to LEN_LO.
  - LEN_LO: s_ready_o=1. Capture the low byte of N.
    - N=0: go to RUN.
    - N>MAX_LEN: go to ERROR.
    - Otherwise go to DAT_HI.
  - DAT_HI: s_ready_o=1. Capture word[15:8], then go to DAT_LO.
  - DAT_LO: s_ready_o=1. Capture word[7:0], then go to WRITE.
  - WRITE: s_ready_o=0. Assert wr_en_o for exactly one cycle with wr_addr_o=index and wr_data_o=word. Then increment index and words_loaded_o.
    - If index equals N, go to RUN (or CSUM_HI when the feature is enabled).
    - Otherwise go to DAT_HI.
- Write latency: wr_en_o is high in the cycle after the LO byte is accepted. Peak throughput is one word per 3 cycles.
- Addresses run 0..N-1 and never wrap. N=MAX_LEN writes the last address (DEPTH-1) and stops.
- busy_o is 1 in every state except IDLE, RUN and ERROR.
- RUN: cpu_run_o=1, s_ready_o=0. Bytes presented here are not accepted. On load_req_i, drop cpu_run_o in the same edge and go to LEN_HI.
- ERROR: err_o=1, cpu_run_o=0, s_ready_o=0. Only load_req_i exits (to LEN_HI). load_req_i also clears err_o.
- load_req_i arriving mid-session aborts the session and restarts at LEN_HI.
  - words_loaded_o resets to 0.
  - Words already written stay in memory.
  - A WRITE in progress on that edge still completes.
- Reset asserted mid-session: go to IDLE immediately, with no further writes.
- wr_en_o is never high in any state other than WRITE.

Optional Feature:
- Macro: IMEM_BOOT_CSUM_EN.
- Defined:
  - After the last word, states CSUM_HI and CSUM_LO accept a 16-bit trailer.
  - The trailer must equal the modulo-2^16 sum of all N words.
  - Match: go to RUN. Mismatch: go to ERROR (words remain written).
  - N=0 still expects a trailer of 0x0000.
- Undefined: no trailer; go straight to RUN after the last write.

Decomposition:
- Shared package holds:
  - State enum: IDLE, LEN_HI, LEN_LO, DAT_HI, DAT_LO, WRITE, CSUM_HI, CSUM_LO, RUN, ERROR.
  - Instruction opcode constants: RTYPE=2'b00, MOVI=2'b01, JUMP=2'b10, BRANCH=2'b11.
  - IMEM_DEPTH=256 and IMEM_AW=8.
- One natural sub-module: imem_boot_byte_pack.
  - Assembles HI/LO byte pairs into 16-bit words.
  - Drives the 16-bit LEN and checksum fields.
  - The FSM stays in the top module.

Test Plan:
- Stream 00 03 | 28 28 | 48 50 | 40 54 → writes 0x2828@0, 0x4850@1, 0x4054@2, each one cycle after its LO byte. Then cpu_run_o=1 and words_loaded_o=3.
- Stream 00 00 → RUN directly, with no wr_en_o pulse.
- LEN=0x0101 (257) with DEPTH=256 → ERROR, err_o=1, cpu_run_o=0, no writes. A following load_req_i clears err_o.
- LEN=0x0100 with 256 words → last write at address 0xFF, no wrap, then RUN.
- load_req_i while in RUN after word 1 of a new stream → cpu_run_o falls on the same edge and words_loaded_o restarts from 0. Repeat with reset asserted mid-word → IDLE immediately and no write.
- With IMEM_BOOT_CSUM_EN: words 0x0001, 0x0002 then trailer 0x0003 → RUN. Same words with trailer 0x0004 → ERROR, err_o=1.

Source files
------------

// File: rtl/imem_boot_loader_pkg.sv
// ---------------------------------------------------------------------------
// imem_boot_loader_pkg
// Shared definitions for the instruction-memory boot loader: loader FSM
// state encoding, CPU instruction opcode constants and the default
// instruction-memory geometry.
// ---------------------------------------------------------------------------
package imem_boot_loader_pkg;

    // Loader FSM states. CSUM_HI/CSUM_LO are only reachable when the
    // checksum trailer (IMEM_BOOT_CSUM_EN) is compiled in.
    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        LEN_HI  = 4'd1,
        LEN_LO  = 4'd2,
        DAT_HI  = 4'd3,
        DAT_LO  = 4'd4,
        WRITE   = 4'd5,
        CSUM_HI = 4'd6,
        CSUM_LO = 4'd7,
        RUN     = 4'd8,
        ERROR   = 4'd9
    } state_t;

    // Top two bits of the CPU's 16-bit instruction word.
    localparam logic [1:0] RTYPE  = 2'b00;
    localparam logic [1:0] MOVI   = 2'b01;
    localparam logic [1:0] JUMP   = 2'b10;
    localparam logic [1:0] BRANCH = 2'b11;

    localparam int IMEM_DEPTH = 256;
    localparam int IMEM_AW    = 8;

endpackage

// File: rtl/imem_boot_byte_pack.sv
// ---------------------------------------------------------------------------
// imem_boot_byte_pack
// Joins the HI/LO byte pair of a 16-bit stream field (length, instruction
// word or checksum). The HI byte is held in a register; the full word is
// presented combinationally while the LO byte is on the bus, so the caller
// captures the whole field on the same edge that accepts the LO byte.
//
// Ports:
//   clk      in   system clock
//   hi_en    in   capture data_in as the high byte on this edge
//   data_in  in   8-bit host byte
//   word     out  {held high byte, data_in}
// ---------------------------------------------------------------------------
module imem_boot_byte_pack (
    input  logic        clk,
    input  logic        hi_en,
    input  logic [7:0]  data_in,
    output logic [15:0] word
);

    logic [7:0] hi_q;

    // Datapath register: no reset needed, always written before it is used.
    always_ff @(posedge clk) begin
        if (hi_en) begin
            hi_q <= data_in;
        end
    end

    assign word = {hi_q, data_in};

endmodule

// File: rtl/imem_boot_loader.sv
// ---------------------------------------------------------------------------
// imem_boot_loader
// Loads a program from a byte-wide host stream into the instruction memory
// write port, holding the CPU out of execution while loading. Frame:
// LEN_HI, LEN_LO, then N words as HI/LO byte pairs, optionally followed by
// a 16-bit modulo-2^16 checksum of the words.
//
// Optional feature macro: IMEM_BOOT_CSUM_EN (checksum trailer).
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   load_req_i       one-cycle pulse: start (or restart) a load session
//   s_valid_i/s_data_i/s_ready_o   byte stream handshake
//   wr_en_o/wr_addr_o/wr_data_o    instruction memory write port
//   cpu_run_o        CPU may fetch/execute
//   busy_o           load session in progress
//   err_o            sticky error, cleared by load_req_i
//   words_loaded_o   words written in the current or last session
// ---------------------------------------------------------------------------
module imem_boot_loader
    import imem_boot_loader_pkg::*;
#(
    parameter int DEPTH   = IMEM_DEPTH,
    parameter int AW      = IMEM_AW,
    parameter int MAX_LEN = DEPTH
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load_req_i,
    input  logic          s_valid_i,
    input  logic [7:0]    s_data_i,
    output logic          s_ready_o,
    output logic          wr_en_o,
    output logic [AW-1:0] wr_addr_o,
    output logic [15:0]   wr_data_o,
    output logic          cpu_run_o,
    output logic          busy_o,
    output logic          err_o,
    output logic [AW:0]   words_loaded_o
);

    if (DEPTH != (1 << AW)) begin : g_bad_geometry
        $error("imem_boot_loader: DEPTH must equal 2**AW");
    end

`ifdef IMEM_BOOT_CSUM_EN
    localparam state_t END_ST = CSUM_HI;
`else
    localparam state_t END_ST = RUN;
`endif

    state_t      state_q, state_nxt;
    logic        acc;
    logic        hi_en, lo_en;
    logic [15:0] pack_word;
    logic [15:0] len_q;
    logic        last_word;

    assign acc   = s_valid_i && s_ready_o;
    assign hi_en = acc && (state_q == LEN_HI || state_q == DAT_HI || state_q == CSUM_HI);
    assign lo_en = acc && (state_q == LEN_LO || state_q == DAT_LO || state_q == CSUM_LO);

    // words_loaded_o doubles as the write index: both restart together.
    assign last_word = (({{(31-AW){1'b0}}, words_loaded_o} + 32'd1) == {16'd0, len_q});

    imem_boot_byte_pack u_pack (
        .clk     (clk),
        .hi_en   (hi_en),
        .data_in (s_data_i),
        .word    (pack_word)
    );

`ifdef IMEM_BOOT_CSUM_EN
    logic [15:0] csum_q;

    always_ff @(posedge clk) begin
        if (load_req_i) begin
            csum_q <= 16'd0;
        end else if (state_q == DAT_LO && lo_en) begin
            csum_q <= csum_q + pack_word;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (state_q == LEN_LO && lo_en) begin
            len_q <= pack_word;
        end
    end

    // ---- next-state logic ----
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            IDLE:   state_nxt = IDLE;
            LEN_HI: if (acc) state_nxt = LEN_LO;
            LEN_LO: begin
                if (lo_en) begin
                    if (pack_word == 16'd0) begin
                        state_nxt = END_ST;
                    end else if ({16'd0, pack_word} > 32'(MAX_LEN)) begin
                        state_nxt = ERROR;
                    end else begin
                        state_nxt = DAT_HI;
                    end
                end
            end
            DAT_HI: if (acc) state_nxt = DAT_LO;
            DAT_LO: if (acc) state_nxt = WRITE;
            WRITE:  state_nxt = last_word ? END_ST : DAT_HI;
`ifdef IMEM_BOOT_CSUM_EN
            CSUM_HI: if (acc) state_nxt = CSUM_LO;
            CSUM_LO: begin
                if (lo_en) begin
                    state_nxt = (pack_word == csum_q) ? RUN : ERROR;
                end
            end
`endif
            RUN:    state_nxt = RUN;
            ERROR:  state_nxt = ERROR;
            default: state_nxt = IDLE;
        endcase
        // A new request overrides everything, including a session in flight.
        if (load_req_i) begin
            state_nxt = LEN_HI;
        end
    end

    // ---- state and registered outputs (decoded from next state) ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            s_ready_o      <= 1'b0;
            wr_en_o        <= 1'b0;
            wr_addr_o      <= '0;
            wr_data_o      <= 16'd0;
            cpu_run_o      <= 1'b0;
            busy_o         <= 1'b0;
            err_o          <= 1'b0;
            words_loaded_o <= '0;
        end else begin
            state_q   <= state_nxt;
            s_ready_o <= (state_nxt == LEN_HI) || (state_nxt == LEN_LO) ||
                         (state_nxt == DAT_HI) || (state_nxt == DAT_LO) ||
                         (state_nxt == CSUM_HI) || (state_nxt == CSUM_LO);
            wr_en_o   <= (state_nxt == WRITE);
            cpu_run_o <= (state_nxt == RUN);
            busy_o    <= !((state_nxt == IDLE) || (state_nxt == RUN) || (state_nxt == ERROR));
            // ERROR is only left through load_req_i, so this is sticky.
            err_o     <= (state_nxt == ERROR);
            if (state_nxt == WRITE) begin
                wr_addr_o <= words_loaded_o[AW-1:0];
                wr_data_o <= pack_word;
            end
            if (load_req_i) begin
                words_loaded_o <= '0;
            end else if (state_q == WRITE) begin
                words_loaded_o <= words_loaded_o + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
module tb_imem_boot_loader;

    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          load_req_i;
    logic          s_valid_i;
    logic [7:0]    s_data_i;
    logic          s_ready_o;
    logic          wr_en_o;
    logic [AW-1:0] wr_addr_o;
    logic [15:0]   wr_data_o;
    logic          cpu_run_o;
    logic          busy_o;
    logic          err_o;
    logic [AW:0]   words_loaded_o;

    int n_cmp = 0;
    int n_err = 0;

    logic [23:0] exp_q[$];     // {addr, data} of each expected write
    logic [15:0] exp_sum;

    imem_boot_loader dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .load_req_i     (load_req_i),
        .s_valid_i      (s_valid_i),
        .s_data_i       (s_data_i),
        .s_ready_o      (s_ready_o),
        .wr_en_o        (wr_en_o),
        .wr_addr_o      (wr_addr_o),
        .wr_data_o      (wr_data_o),
        .cpu_run_o      (cpu_run_o),
        .busy_o         (busy_o),
        .err_o          (err_o),
        .words_loaded_o (words_loaded_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Write monitor: every strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (wr_en_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", {8'd0, wr_addr_o, wr_data_o}, 32'hFFFF_FFFF);
            end else begin
                logic [23:0] e;
                e = exp_q.pop_front();
                chk("write_addr_data", {8'd0, wr_addr_o, wr_data_o}, {8'd0, e});
            end
        end
    end

    // All tasks are entered and left at 1ns after a rising edge.
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_load();
        load_req_i = 1'b1;
        cyc(1);
        load_req_i = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int guard;
        guard = 0;
        s_valid_i = 1'b1;
        s_data_i  = b;
        while (!s_ready_o && guard < 40) begin
            cyc(1);
            guard++;
        end
        if (guard >= 40) chk("ready_timeout", 32'd0, 32'd1);
        cyc(1);
        s_valid_i = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] addr, input logic [15:0] w);
        exp_q.push_back({addr, w});
        exp_sum = exp_sum + w;
        send_byte(w[15:8]);
        send_byte(w[7:0]);
        chk("write_latency", {31'd0, wr_en_o}, 32'd1);
    endtask

    // Finish a frame: checksum trailer when built in, else the WRITE cycle.
    task automatic finish_frame(input logic [15:0] trailer);
`ifdef IMEM_BOOT_CSUM_EN
        send_byte(trailer[15:8]);
        send_byte(trailer[7:0]);
`else
        if (trailer != 16'hFFFF) cyc(1);
`endif
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; load_req_i = 1'b0; s_valid_i = 1'b0; s_data_i = 8'h00;
        exp_sum = 16'd0;
        cyc(3);
        chk("rst_ready", {31'd0, s_ready_o}, 0);
        chk("rst_wr_en", {31'd0, wr_en_o}, 0);
        chk("rst_addr_data", {8'd0, wr_addr_o, wr_data_o}, 0);
        chk("rst_run_busy_err", {29'd0, cpu_run_o, busy_o, err_o}, 0);
        chk("rst_words", {23'd0, words_loaded_o}, 0);
        @(negedge clk); rst_n = 1'b1;
        cyc(2);
        chk("idle_ready", {31'd0, s_ready_o}, 0);

        // Three-word program
        pulse_load();
        chk("load_busy", {31'd0, busy_o}, 1);
        exp_sum = 16'd0;
        send_byte(8'h00); send_byte(8'h03);
        send_word(8'd0, 16'h2828);
        send_word(8'd1, 16'h4850);
        send_word(8'd2, 16'h4054);
        finish_frame(exp_sum);
        chk("p3_run", {31'd0, cpu_run_o}, 1);
        chk("p3_words", {23'd0, words_loaded_o}, 3);
        chk("p3_busy_ready", {30'd0, busy_o, s_ready_o}, 0);

        // Empty program straight from RUN
        pulse_load();
        chk("reload_run_drop", {31'd0, cpu_run_o}, 0);
        chk("reload_words_clr", {23'd0, words_loaded_o}, 0);
        exp_sum = 16'd0;
        send_byte(8'h00); send_byte(8'h00);
`ifdef IMEM_BOOT_CSUM_EN
        finish_frame(16'h0000);
`endif
        chk("n0_run", {31'd0, cpu_run_o}, 1);
        chk("n0_words", {23'd0, words_loaded_o}, 0);

        // Oversize length
        pulse_load();
        send_byte(8'h01); send_byte(8'h01);
        chk("big_err", {31'd0, err_o}, 1);
        chk("big_run_busy", {30'd0, cpu_run_o, busy_o}, 0);
        cyc(3);
        chk("big_err_sticky", {31'd0, err_o}, 1);
        pulse_load();
        chk("err_cleared", {31'd0, err_o}, 0);
        exp_sum = 16'd0;
        send_byte(8'h00); send_byte(8'h00);
`ifdef IMEM_BOOT_CSUM_EN
        finish_frame(16'h0000);
`endif
        chk("after_err_run", {31'd0, cpu_run_o}, 1);

        // Full-depth program
        pulse_load();
        exp_sum = 16'd0;
        send_byte(8'h01); send_byte(8'h00);
        for (int i = 0; i < 256; i++) begin
            send_word(8'(i), 16'(i * 16'h1357 + 16'h00A5));
        end
        finish_frame(exp_sum);
        chk("full_run", {31'd0, cpu_run_o}, 1);
        chk("full_words", {23'd0, words_loaded_o}, 256);
        chk("full_last_addr", {24'd0, wr_addr_o}, 32'hFF);

        // Restart from RUN, then abort after word 1
        pulse_load();
        chk("rerun_drop", {31'd0, cpu_run_o}, 0);
        exp_sum = 16'd0;
        send_byte(8'h00); send_byte(8'h02);
        send_word(8'd0, 16'hC001);
        cyc(1);
        chk("abort_words_pre", {23'd0, words_loaded_o}, 1);
        pulse_load();
        chk("abort_words_clr", {23'd0, words_loaded_o}, 0);
        chk("abort_busy", {31'd0, busy_o}, 1);

        // Reset in the middle of a word
        send_byte(8'h00); send_byte(8'h02);
        send_byte(8'hAB);
        s_valid_i = 1'b1; s_data_i = 8'hCD;
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_outputs", {28'd0, s_ready_o, wr_en_o, busy_o, cpu_run_o}, 0);
        cyc(3);
        s_valid_i = 1'b0;
        chk("midrst_words", {23'd0, words_loaded_o}, 0);
        @(negedge clk); rst_n = 1'b1;
        cyc(2);
        chk("midrst_idle", {29'd0, s_ready_o, busy_o, wr_en_o}, 0);

`ifdef IMEM_BOOT_CSUM_EN
        pulse_load();
        exp_sum = 16'd0;
        send_byte(8'h00); send_byte(8'h02);
        send_word(8'd0, 16'h0001);
        send_word(8'd1, 16'h0002);
        send_byte(8'h00); send_byte(8'h03);
        chk("csum_ok_run", {30'd0, cpu_run_o, err_o}, 2);
        pulse_load();
        exp_sum = 16'd0;
        send_byte(8'h00); send_byte(8'h02);
        send_word(8'd0, 16'h0001);
        send_word(8'd1, 16'h0002);
        send_byte(8'h00); send_byte(8'h04);
        chk("csum_bad_err", {30'd0, cpu_run_o, err_o}, 1);
`endif

        cyc(4);
        chk("scoreboard_empty", 32'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
